io_bus_scheduler: RTL

Shares the 8-bit TinyTapeOut pin bus between two requesters: the instruction-fetch port and the load/store data port of the MIPS core. It serialises each 32-bit access into LSB-first byte beats on `address_out`/`data_output`, and reassembles 32-bit read data from `data_input`. It sits between the core's fetch/memory stages and the chip IO pins, and owns all pin-level sequencing. Requesters see a simple request/acknowledge handshake.

---
 rtl/io_bus_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/io_bus_scheduler.sv
// Two-port (fetch / load-store) scheduler for the 8-bit pin bus, 32-bit accesses as LSB-first byte beats.
// Latency: write ack at cycle 5, read ack at cycle 9+TURN_CYCLES after the IDLE sample cycle.
// Backpressure: one access in flight, loser stays pending; `define IO_SCHED_ROUND_ROBIN_EN for round-robin arbitration.
module io_bus_scheduler #(
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] rdata,
  input  logic [7:0]  data_input,
  output logic [7:0]  address_out,
  output logic [7:0]  data_output,
  output logic [1:0]  bus_cmd,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, READ, DONE} state_t;

  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  beat, turn_cnt;
  logic        id_data, we_q;
  logic [31:0] addr_q, wdata_q, rdata_shadow;
  logic        grant_d, grant_any;

  assign grant_any = f_req | d_req;

`ifdef IO_SCHED_ROUND_ROBIN_EN
  // last_grant: 1 = data port was granted last, 0 = fetch
  logic last_grant;
  assign grant_d = d_req & (~f_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == IDLE && grant_any)
      last_grant <= grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ADDR;
      ADDR:    if (beat == 2'd3) state_nxt = we_q ? DONE : TURN;
      TURN:    if (turn_cnt == TURN_LAST) state_nxt = READ;
      READ:    if (beat == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    address_out = 8'h00;
    data_output = 8'h00;
    bus_cmd     = 2'b00;
    f_ack       = 1'b0;
    d_ack       = 1'b0;
    case (state)
      ADDR: begin
        address_out = addr_q[{beat, 3'b000} +: 8];
        data_output = we_q ? wdata_q[{beat, 3'b000} +: 8] : 8'h00;
        bus_cmd     = we_q ? 2'b10 : 2'b01;
      end
      TURN: begin
        address_out = 8'hFF;
        bus_cmd     = 2'b01;
      end
      READ: bus_cmd = 2'b01;
      DONE: begin
        f_ack = ~id_data;
        d_ack = id_data;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= 2'd0;
      turn_cnt     <= 2'd0;
      id_data      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_shadow <= 32'h0;
      rdata        <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        beat     <= 2'd0;
        turn_cnt <= 2'd0;
      end else begin
        if (state == ADDR || state == READ) beat <= beat + 2'd1;
        if (state == TURN) turn_cnt <= turn_cnt + 2'd1;
      end

      if (state == IDLE && grant_any) begin
        id_data <= grant_d;
        addr_q  <= grant_d ? d_addr : f_addr;
        we_q    <= grant_d & d_we;
        wdata_q <= d_wdata;
      end

      // The last byte bypasses the shadow so rdata is already valid in DONE
      if (state == READ) begin
        rdata_shadow[{beat, 3'b000} +: 8] <= data_input;
        if (beat == 2'd3) rdata <= {data_input, rdata_shadow[23:0]};
      end
    end
  end

endmodule
